// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/last framing
// A word is taken on load_valid&load_ready and shifted out one bit per clock.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg_next;
  logic             load;

  // out_last is only ever set in SHIFT, so it marks the reload slot
  assign load_ready = resetn && ((state == IDLE) || out_last);
  assign load       = load_valid && load_ready;
  assign busy       = (state == SHIFT);
  assign sreg_next  = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

  // sreg holds the bit currently on out at its transmit end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      state     <= SHIFT;
      sreg      <= load_data;
      cnt       <= '0;
      out       <= LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
      out_valid <= 1'b1;
      out_last  <= 1'b0;
    end else if (state == SHIFT) begin
      if (cnt == LAST_CNT) begin
        state     <= IDLE;
        sreg      <= '0;
        cnt       <= '0;
        out       <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        sreg     <= sreg_next;
        cnt      <= cnt + CW'(1);
        out      <= LSB_FIRST ? sreg_next[0] : sreg_next[WIDTH-1];
        out_last <= (cnt == PRE_LAST);
      end
    end
  end

endmodule
